// File: rtl/multi_dir_ctrl.sv
// multi_dir_ctrl
// Per-player direction controller for the snake game. Each player's four
// direction buttons are edge-detected, a single candidate is picked
// (priority up > left > down > right), no-op and reversal turns are
// rejected, and legal turns are queued in a small FIFO. On every tick each
// player with a non-empty queue commits the queue head to its direction.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   tick      game-step strobe, one clk wide, shared by all players
//   btn       per player p, [4p+3:4p] = {right, down, left, up}, debounced levels
//   dir       committed direction of player p at [2p+1:2p] (0=UP 1=LEFT 2=DOWN 3=RIGHT)
//   turned    one-cycle pulse when player p's dir was loaded on a tick
//   q_count   queued-turn count of player p at [3p+2:3p]
//   overflow  sticky: a legal turn of player p was dropped on a full queue
//
// Build option:
//   DIR_REVERSE_EN  when defined, reversals are legal; only no-op turns are
//                   rejected.
module multi_dir_ctrl #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         QUEUE_DEPTH = 2,
  parameter logic [1:0] RESET_DIR   = 2'd3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [4*NUM_PLAYERS-1:0] btn,
  output logic [2*NUM_PLAYERS-1:0] dir,
  output logic [NUM_PLAYERS-1:0]   turned,
  output logic [3*NUM_PLAYERS-1:0] q_count,
  output logic [NUM_PLAYERS-1:0]   overflow
);

  localparam int            PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [2:0]    FULL = 3'(QUEUE_DEPTH);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]    btn_prev;
    logic [3:0]    press;
    logic [1:0]    cand;
    logic          cand_vld;
    logic [1:0]    ref_dir;
    logic          legal;
    logic          pop;
    logic          push;
    logic          drop;
    logic [1:0]    dir_r;
    logic          turned_r;
    logic          ovf_r;
    logic [2:0]    count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] newest;
    logic [1:0]    mem [QUEUE_DEPTH];

    assign press    = btn[4*p +: 4] & ~btn_prev;
    assign cand_vld = |press;

    // Button bit index equals the direction code, so the lowest set bit wins.
    always_comb begin
      cand = 2'd3;
      if (press[2]) cand = 2'd2;
      if (press[1]) cand = 2'd1;
      if (press[0]) cand = 2'd0;
    end

    // Legality is judged against the last turn already queued, so a burst of
    // presses between ticks is checked as a chain of turns.
    assign newest  = (tail == '0) ? LAST : tail - 1'b1;
    assign ref_dir = (count != 3'd0) ? mem[newest] : dir_r;

`ifdef DIR_REVERSE_EN
    assign legal = cand_vld && (cand != ref_dir);
`else
    assign legal = cand_vld && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
`endif

    assign pop  = tick && (count != 3'd0);
    assign push = legal && ((count != FULL) || pop);
    assign drop = legal && (count == FULL) && !pop;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        btn_prev <= 4'b0000;
        dir_r    <= RESET_DIR;
        turned_r <= 1'b0;
        ovf_r    <= 1'b0;
        count    <= 3'd0;
        head     <= '0;
        tail     <= '0;
      end else begin
        btn_prev <= btn[4*p +: 4];
        turned_r <= pop;
        if (pop) begin
          dir_r <= mem[head];
          head  <= (head == LAST) ? '0 : head + 1'b1;
        end
        if (push) begin
          tail <= (tail == LAST) ? '0 : tail + 1'b1;
        end
        if (drop) begin
          ovf_r <= 1'b1;
        end
        count <= count + 3'(push) - 3'(pop);
      end
    end

    // Entries are only read while counted as valid, so storage needs no reset.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[tail] <= cand;
      end
    end

    assign dir[2*p +: 2]     = dir_r;
    assign turned[p]         = turned_r;
    assign q_count[3*p +: 3] = count;
    assign overflow[p]       = ovf_r;
  end

endmodule

// File: tb/tb_multi_dir_ctrl.sv
// Scoreboard bench for multi_dir_ctrl. A queue-based reference model predicts
// each cycle's outputs and each committed turn; a monitor compares the DUT
// against those predictions one step after every rising edge.
module tb_multi_dir_ctrl;
  localparam int         NP = 2;
  localparam int         QD = 2;
  localparam logic [1:0] RD = 2'd3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick = 1'b0;
  logic [4*NP-1:0] btn = '0;
  logic [2*NP-1:0] dir;
  logic [NP-1:0]   turned;
  logic [3*NP-1:0] q_count;
  logic [NP-1:0]   overflow;

  always #5 clk = ~clk;

  multi_dir_ctrl #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(QD), .RESET_DIR(RD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn),
    .dir(dir), .turned(turned), .q_count(q_count), .overflow(overflow)
  );

  typedef struct {
    logic [2*NP-1:0] dir;
    logic [NP-1:0]   turned;
    logic [3*NP-1:0] qc;
    logic [NP-1:0]   ovf;
  } snap_t;

  snap_t      exp_q[$];
  int         turn_q[NP][$];
  int         mq[NP][$];
  int         mdir[NP];
  bit         movf[NP];
  logic [3:0] mprev[NP];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      turn_q[p].delete();
      mdir[p]  = RD;
      movf[p]  = 1'b0;
      mprev[p] = 4'b0000;
    end
    exp_q.delete();
  endfunction

  // One clock edge of the specified behaviour, for every player.
  function automatic void model_step(logic [4*NP-1:0] b, logic t);
    snap_t      s;
    logic [3:0] pr;
    int         cand;
    int         size0;
    int         refd;
    bit         popping;
    bit         legal;
    for (int p = 0; p < NP; p++) begin
      pr       = b[4*p +: 4] & ~mprev[p];
      mprev[p] = b[4*p +: 4];
      cand = -1;
      for (int k = 0; k < 4; k++) if (pr[k] && cand < 0) cand = k;
      size0   = mq[p].size();
      refd    = (size0 > 0) ? mq[p][$] : mdir[p];
      popping = t && (size0 > 0);
      legal   = (cand >= 0) && (cand != refd);
`ifndef DIR_REVERSE_EN
      legal   = legal && (cand != (refd ^ 2));
`endif
      if (popping) begin
        mdir[p] = mq[p].pop_front();
        turn_q[p].push_back(mdir[p]);
      end
      if (legal) begin
        if (size0 < QD || popping) mq[p].push_back(cand);
        else movf[p] = 1'b1;
      end
      s.turned[p]     = popping;
      s.dir[2*p +: 2] = 2'(mdir[p]);
      s.qc[3*p +: 3]  = 3'(mq[p].size());
      s.ovf[p]        = movf[p];
    end
    exp_q.push_back(s);
  endfunction

  task automatic cycle(input logic [4*NP-1:0] b, input logic t);
    @(negedge clk);
    btn  = b;
    tick = t;
    model_step(b, t);
  endtask

  // Asserted together with a tick to show reset wins and clears the queues at once.
  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b1;
    #1;
    chk("rst_dir", 32'(dir), 32'({NP{RD}}));
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_turned", 32'(turned), 32'd0);
    model_reset();
    tick = 1'b0;
    btn  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step(btn, tick);
  endtask

  initial begin : monitor
    snap_t s;
    int    e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("dir", 32'(dir), 32'(s.dir));
        chk("q_count", 32'(q_count), 32'(s.qc));
        chk("overflow", 32'(overflow), 32'(s.ovf));
        chk("turned", 32'(turned), 32'(s.turned));
        for (int p = 0; p < NP; p++) begin
          if (turned[p]) begin
            if (turn_q[p].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL turn_unexpected player=%0d actual_dir=%0d required=no_turn", p, dir[2*p +: 2]);
            end else begin
              e = turn_q[p].pop_front();
              chk("turn_dir", 32'(dir[2*p +: 2]), 32'(e));
            end
          end
        end
      end
    end
  end

  localparam logic [3:0] UP = 4'b0001, LF = 4'b0010, DN = 4'b0100, RT = 4'b1000, NB = 4'b0000;

  initial begin : stimulus
    logic [4*NP-1:0] b;
    model_reset();
    do_reset();
    repeat (3) cycle('0, 1'b1);

    repeat (5) cycle({NB, UP}, 1'b0);
    cycle('0, 1'b1);
    repeat (2) cycle('0, 1'b0);

    do_reset();
    cycle({NB, LF}, 1'b0);
    cycle('0, 1'b0);
    cycle({NB, DN}, 1'b0);
    cycle('0, 1'b0);
    cycle({NB, LF}, 1'b0);
    cycle('0, 1'b0);
    cycle('0, 1'b1);
    cycle('0, 1'b1);
    cycle('0, 1'b0);

    do_reset();
    cycle({NB, UP}, 1'b0); cycle('0, 1'b0);
    cycle({NB, LF}, 1'b0); cycle('0, 1'b0);
    cycle({NB, DN}, 1'b0); cycle('0, 1'b0);
    do_reset();
    cycle({NB, UP}, 1'b0); cycle('0, 1'b0);
    cycle({NB, LF}, 1'b0); cycle('0, 1'b0);
    cycle({NB, DN}, 1'b1); cycle('0, 1'b0);
    repeat (3) cycle('0, 1'b1);

    do_reset();
    repeat (10) cycle({NB, UP | RT}, 1'b0);
    cycle('0, 1'b1);
    cycle('0, 1'b0);

    do_reset();
    cycle({NB, UP}, 1'b0); cycle('0, 1'b0);
    cycle({LF, LF}, 1'b0); cycle('0, 1'b0);
    do_reset();
    cycle({NB, LF}, 1'b1);
    cycle('0, 1'b1);
    cycle('0, 1'b0);

    b = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4*NP; k++) if ($urandom_range(3) == 0) b[k] = ~b[k];
      cycle(b, ($urandom_range(3) == 0));
      if ($urandom_range(599) == 0) begin
        do_reset();
        b = '0;
      end
    end

    repeat (QD + 2) cycle('0, 1'b1);
    cycle('0, 1'b0);
    @(negedge clk);
    chk("turns_drained", 32'(turn_q[0].size() + turn_q[NP-1].size()), 32'd0);
    chk("snapshots_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
